fetch_inst_buffer: RTL
======================

FETCH_INST_BUFFER -- requirements
Module: fetch_inst_buffer

Interface
- REQ-001 SHALL have parameter IN_WIDTH, default 4, meaning max instructions enqueued per cycle (frontend fetch width).
- REQ-002 SHALL have parameter OUT_WIDTH, default 4, meaning max instructions dequeued per cycle (decode width).
- REQ-003 SHALL have parameter DEPTH, default 16, meaning entry count; power of two, DEPTH >= IN_WIDTH+OUT_WIDTH.
- REQ-004 SHALL have parameter ENTRY_W, default 64, meaning payload bits per instruction entry.
- REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
- REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
- REQ-007 SHALL have port i_squash_vld, input, 1, pipeline flush.
- REQ-008 SHALL have port i_inst_vld, input, IN_WIDTH, per-lane valid; may be sparse.
- REQ-009 SHALL have port i_inst, input, IN_WIDTH x ENTRY_W, per-lane payload.
- REQ-010 SHALL have port o_stall, output, 1, to frontend: input not accepted this cycle.
- REQ-011 SHALL have port i_backend_stall, input, 1, from decode: no dequeue this cycle.
- REQ-012 SHALL have port o_inst_vld, output, OUT_WIDTH, per-lane output valid.
- REQ-013 SHALL have port o_inst, output, OUT_WIDTH x ENTRY_W, per-lane output payload.
- REQ-014 SHALL have port o_count, output, clog2(DEPTH)+1, current occupancy.

Function
- REQ-015 o_stall SHALL be 1 when (DEPTH - count) < IN_WIDTH, from registered state only (no input-to-o_stall path).
- REQ-016 When o_stall=0 and i_squash_vld=0, all set i_inst_vld lanes SHALL be enqueued in ascending lane order, compacted (no holes), same cycle.
- REQ-017 When o_stall=1, inputs SHALL be ignored entirely; frontend holds them.
- REQ-018 o_inst_vld lane k SHALL be 1 iff k < min(count, OUT_WIDTH) and i_squash_vld=0; o_inst lane k SHALL be entry head+k (combinational read of registered storage).
- REQ-019 When i_backend_stall=0, all valid output lanes SHALL be dequeued that cycle; when 1, none, outputs held stable.
- REQ-020 Enqueue and dequeue in the same cycle SHALL both occur; next count = count + enq - deq.
- REQ-021 Head/tail pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; entries straddling wrap SHALL read/write correctly.
- REQ-022 i_squash_vld=1 SHALL set count=0 and head=tail next cycle, drop that cycle's inputs and suppress that cycle's outputs; squash overrides enqueue/dequeue.
- REQ-023 Dequeue latency from enqueue SHALL be one cycle (entry written at edge N visible on o_inst after edge N); no same-cycle bypass.
- REQ-024 Payload of invalid output lanes is don't-care; only o_inst_vld qualifies.

Reset
- REQ-025 rst=1 at an edge SHALL set count=0, head=0, tail=0, overriding squash and all traffic, including mid-operation.
- REQ-026 During/after reset: o_stall=0, o_inst_vld=0, o_count=0; storage contents need not be reset.

Configuration
- REQ-027 Macro FETCHBUF_PERF_EN defined: SHALL add output o_perf_stall_cnt (32 bits), incremented each cycle o_stall=1, saturating at 0xFFFFFFFF, zeroed only by rst.
- REQ-028 Macro FETCHBUF_PERF_EN undefined: port and counter SHALL not exist; all other behaviour identical.

Verification
- REQ-029 Defaults; reset, then i_inst_vld=4'b1111 payloads 1..4, i_backend_stall=0 -> next cycle o_inst_vld=4'b1111, o_inst=1,2,3,4, o_count=4.
- REQ-030 Sparse input i_inst_vld=4'b1010 payloads A0..A3 -> next cycle o_inst_vld=4'b0011, o_inst lane0=A1, lane1=A3.
- REQ-031 i_backend_stall=1, four full enqueues -> o_count=16 after 4 cycles, o_stall=1 at count 13..16; fifth group ignored; release stall -> outputs 4/cycle in enqueue order, o_stall drops once count <= 12.
- REQ-032 Fill to count=14 via partial dequeues so tail wraps past index 15 -> output order matches enqueue order across wrap, no loss/duplication.
- REQ-033 count=9, i_squash_vld=1 with i_inst_vld=4'b1111 -> that cycle o_inst_vld=0; next cycle o_count=0, o_inst_vld=0, squash-cycle inputs absent.
- REQ-034 FETCHBUF_PERF_EN defined, hold o_stall=1 for 10 cycles -> o_perf_stall_cnt=10; assert rst -> 0.

Source files
------------

// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: multi-lane circular instruction buffer between
// fetch and decode. Compacts sparse input lanes, drains up to OUT_WIDTH/cycle.
//
// Parameters:
//   IN_WIDTH  - max instructions enqueued per cycle
//   OUT_WIDTH - max instructions dequeued per cycle
//   DEPTH     - entry count (power of two, >= IN_WIDTH+OUT_WIDTH)
//   ENTRY_W   - payload bits per entry
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   i_squash_vld      - flush: empties buffer, drops inputs, hides outputs
//   i_inst_vld/i_inst - per-lane input valid / payload (lane k at [k*ENTRY_W +: ENTRY_W])
//   o_stall           - buffer cannot take a full input group this cycle
//   i_backend_stall   - decode not consuming this cycle
//   o_inst_vld/o_inst - per-lane output valid / payload, lane k = entry head+k
//   o_count           - current occupancy
//   o_perf_stall_cnt  - saturating count of o_stall cycles
//                       (only when FETCHBUF_PERF_EN is defined)

module fetch_inst_buffer #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 4,
    parameter int DEPTH     = 16,
    parameter int ENTRY_W   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_squash_vld,
    input  logic [IN_WIDTH-1:0]           i_inst_vld,
    input  logic [IN_WIDTH*ENTRY_W-1:0]   i_inst,
    output logic                          o_stall,
    input  logic                          i_backend_stall,
    output logic [OUT_WIDTH-1:0]          o_inst_vld,
    output logic [OUT_WIDTH*ENTRY_W-1:0]  o_inst,
    output logic [$clog2(DEPTH):0]        o_count
`ifdef FETCHBUF_PERF_EN
    ,
    output logic [31:0]                   o_perf_stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] IN_C    = CW'(IN_WIDTH);
    localparam logic [CW-1:0] OUT_C   = CW'(OUT_WIDTH);

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [CW-1:0] count_q;
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;

    logic          enq_ok;
    logic [CW-1:0] enq_cnt;
    logic [CW-1:0] deq_cnt;
    logic [CW-1:0] avail;

    logic [IN_WIDTH-1:0] wr_en;
    logic [PW-1:0]       wr_idx [IN_WIDTH];

    // Stall looks only at registered occupancy so the frontend never
    // sees a combinational path from its own valids.
    assign o_stall = (DEPTH_C - count_q) < IN_C;
    assign o_count = count_q;

    assign enq_ok = !o_stall && !i_squash_vld;

    // Running prefix of valid lanes gives each lane its compacted slot.
    always_comb begin
        enq_cnt = '0;
        wr_en   = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            wr_idx[i] = tail_q + enq_cnt[PW-1:0];
            wr_en[i]  = enq_ok && i_inst_vld[i];
            if (i_inst_vld[i]) begin
                enq_cnt = enq_cnt + CW'(1);
            end
        end
        if (!enq_ok) begin
            enq_cnt = '0;
        end
    end

    assign avail = (count_q < OUT_C) ? count_q : OUT_C;

    always_comb begin
        deq_cnt = '0;
        if (!i_squash_vld && !i_backend_stall) begin
            deq_cnt = avail;
        end
    end

    always_comb begin
        o_inst_vld = '0;
        o_inst     = '0;
        for (int k = 0; k < OUT_WIDTH; k++) begin
            o_inst_vld[k] = (CW'(k) < count_q) && !i_squash_vld;
            o_inst[k*ENTRY_W +: ENTRY_W] = mem[head_q + PW'(k)];
        end
    end

    // Storage is not reset; occupancy alone qualifies contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (wr_en[i]) begin
                mem[wr_idx[i]] <= i_inst[i*ENTRY_W +: ENTRY_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (i_squash_vld) begin
            count_q <= '0;
            head_q  <= tail_q;
        end else begin
            count_q <= count_q + enq_cnt - deq_cnt;
            head_q  <= head_q + deq_cnt[PW-1:0];
            tail_q  <= tail_q + enq_cnt[PW-1:0];
        end
    end

`ifdef FETCHBUF_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_perf_stall_cnt <= '0;
        end else if (o_stall && (o_perf_stall_cnt != 32'hFFFF_FFFF)) begin
            o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
